// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, memory access size and fetch FSM states for the instruction fetch unit.
// Contents: XLEN, INSTR_W, MEM_SIZE_WORD, fetch_state_e (ST_RUN / ST_HALT).
package fetch_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_W = 32;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd3;
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular buffer holding fetched {pc, instr} entries.
// Ports: i_clock, i_reset_n (sync, active-low), i_push/i_data write side,
//        i_pop/o_data read side (o_data is the oldest entry), i_flush empties the buffer,
//        o_count is the current occupancy. Pushes when full and pops when empty are ignored.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  logic [W-1:0]                 i_data,
   output logic [W-1:0]                 o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_rd, r_wr;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;
   assign w_push  = i_push && (r_cnt != CW'(DEPTH));
   assign w_pop   = i_pop && (r_cnt != '0);
   assign o_data  = r_mem[r_rd];
   assign o_count = r_cnt;
   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n || i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + PW'(1);
         if (w_pop) r_rd <= (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + PW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
   always_ff @(posedge i_clock) begin
      if (i_reset_n && !i_flush && w_push) r_mem[r_wr] <= i_data;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: sequential word fetch into a small buffer with redirect and optional misalign trap.
// Ports: clock, reset_n (sync, active-low); imem_addr/imem_size/imem_data memory side;
//        redirect_valid/redirect_pc control-flow redirect; out_valid/out_ready/out_instr/out_pc
//        decode handshake; fetch_fault misaligned-redirect flag.
// Build option: define FETCH_MISALIGN_TRAP_EN to halt with fetch_fault on a misaligned redirect;
//        otherwise redirect targets are word-aligned by dropping the low two bits.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic [XLEN-1:0]    imem_addr,
   output logic [1:0]         imem_size,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [XLEN-1:0]    out_pc,
   output logic               fetch_fault
);
   localparam int CW = $clog2(DEPTH+1);
   logic [XLEN-1:0]         r_pc;
   fetch_state_e            r_state, w_state_nxt;
   logic [CW-1:0]           w_count;
   logic                    w_run, w_push, w_pop, w_misalign;
   logic [XLEN+INSTR_W-1:0] w_head;
   assign imem_addr  = r_pc;
   assign imem_size  = MEM_SIZE_WORD;
   assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign out_pc     = w_head[XLEN+INSTR_W-1:INSTR_W];
   assign out_instr  = w_head[INSTR_W-1:0];
   always_ff @(posedge clock) begin
      r_state <= !reset_n ? ST_RUN : w_state_nxt;
   end
   // Redirect wins over this cycle's push and pop; the buffer flush rides on redirect_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_run       = (r_state == ST_RUN);
      out_valid   = w_run && (w_count != '0);
      w_push      = w_run && (w_count != CW'(DEPTH)) && !redirect_valid;
      w_pop       = out_valid && out_ready && !redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_misalign) w_state_nxt = ST_HALT;
`endif
   end
   always_ff @(posedge clock) begin
      if (!reset_n) r_pc <= RESET_PC;
      else if (redirect_valid) r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (w_push) r_pc <= r_pc + 32'd4;
   end
`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_fault;
   always_ff @(posedge clock) begin
      if (!reset_n) r_fault <= 1'b0;
      else if (w_misalign) r_fault <= 1'b1;
   end
   assign fetch_fault = r_fault;
`else
   assign fetch_fault = 1'b0 & w_misalign;
`endif
   fetch_fifo #(.DEPTH(DEPTH), .W(XLEN+INSTR_W)) u_fifo (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_flush   (redirect_valid),
      .i_data    ({r_pc, imem_data}),
      .o_data    (w_head),
      .o_count   (w_count)
   );
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, fetch buffer entries (legal 2..8).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory.
REQ-006 SHALL have port imem_size  output  2  access size to instruction memory.
REQ-007 SHALL have port imem_data  input  32  big-endian word returned for imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port out_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port out_ready  input  1  decode accepts head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  32  PC of head instruction.
REQ-014 SHALL have port fetch_fault  output  1  misaligned-redirect fault flag.

Function
REQ-015 SHALL drive imem_size constantly to 2'd3 (4-byte word).
REQ-016 SHALL drive imem_addr combinationally from the fetch PC register.
REQ-017 SHALL issue a fetch in a cycle when state RUN and buffer count < DEPTH; at that posedge push {pc, imem_data} and pc <= pc + 4.
REQ-018 SHALL treat memory data as valid at the posedge ending the cycle the address was driven (one-cycle fetch-to-buffer latency).
REQ-019 SHALL assert out_valid iff count != 0; out_instr/out_pc SHALL show the oldest entry.
REQ-020 SHALL pop head at posedge when out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-021 SHALL not push when full, even if a pop occurs the same cycle (no full-bypass).
REQ-022 SHALL, on redirect_valid at posedge, flush buffer (count <= 0), load pc <= redirect_pc, and discard that cycle's push and pop; redirect has priority over both.
REQ-023 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-024 SHALL implement states RUN and HALT; RUN->HALT only per REQ-030; HALT exits only via reset.
REQ-025 SHALL keep out_valid = 0 and issue no pushes in HALT.

Reset
REQ-026 SHALL, with reset_n low at posedge, set pc <= RESET_PC, count <= 0, state <= RUN, fetch_fault <= 0.
REQ-027 SHALL give out_valid = 0 the cycle after reset, regardless of prior contents (reset mid-stream discards buffer).
REQ-028 SHALL give reset priority over redirect, push and pop.

Configuration
REQ-029 SHALL compile misaligned-redirect checking under macro FETCH_MISALIGN_TRAP_EN.
REQ-030 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on redirect with redirect_pc[1:0] != 0: flush, set fetch_fault <= 1, enter HALT.
REQ-031 SHALL, without the macro, load pc <= {redirect_pc[31:2], 2'b00} and tie fetch_fault to 0.

Structure
REQ-032 SHALL place XLEN=32, INSTR_W=32, MEM_SIZE_WORD=2'd3 and the RUN/HALT state enum in shared package fetch_pkg.
REQ-033 SHALL implement the buffer as sub-module fetch_fifo (synchronous, DEPTH entries, push/pop/flush, count output).

Verification
REQ-034 SHALL cover: imem bytes 00..0F, RESET_PC=0, out_ready=1 -> out_pc 0,4,8,C with out_instr 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F on consecutive cycles.
REQ-035 SHALL cover: out_ready=0 for 5 cycles -> count saturates at 2, imem_addr holds 8; release -> out_pc 0,4,8 with no loss or duplication.
REQ-036 SHALL cover: buffer full, out_ready=1, redirect_pc=0x8 -> next cycle out_valid=0, following cycle out_pc=8, out_instr=32'h08090A0B.
REQ-037 SHALL cover: RESET_PC=32'hFFFF_FFFC -> after first fetch imem_addr=32'h0.
REQ-038 SHALL cover: redirect_pc=0x6 -> with FETCH_MISALIGN_TRAP_EN fetch_fault=1, out_valid stays 0 until reset; without, next out_pc=4.
REQ-039 SHALL cover: reset_n low for one cycle with buffer full -> next cycle out_valid=0, imem_addr=RESET_PC, fetch_fault=0.
